// File: rtl/ieeedrv_headpos.sv
// Head-position tracker and track-writeback scheduler for one sub-drive.
// Turns stepper phase changes into a clamped head position and saves a dirty track before it changes.
module ieeedrv_headpos #(
   parameter int HOLD_CYC = 16
) (
   input  logic       clk_sys,
   input  logic       reset,
   input  logic       drv_type,
   input  logic       img_mounted,
   input  logic       mtr,
   input  logic [1:0] stp,
   input  logic       we,
   output logic [6:0] track,
   output logic       save_track
);

   typedef enum logic {
      IDLE,
      HOLD
   } state_t;

   state_t      state_q, state_d;
   logic [6:0]  hpos_q, hpos_d;
   logic [6:0]  track_q, track_d;
   logic [1:0]  stp_l_q, stp_l_d;
   logic        mtr_l_q, mtr_l_d;
   logic        dirty_q, dirty_d;
   logic        save_track_q, save_track_d;
   logic [15:0] hold_q, hold_d;

   logic [6:0]  dir_track;
   logic [6:0]  dir_hpos;
   logic [6:0]  hpos_max;
   logic [6:0]  tgt;
   logic [1:0]  stp_inc;
   logic [1:0]  stp_dec;
   logic        need_save;

   assign dir_track = drv_type ? 7'd17 : 7'd38;
   assign dir_hpos  = drv_type ? 7'd34 : 7'd38;
   assign hpos_max  = drv_type ? 7'd69 : 7'd76;
   assign tgt       = drv_type ? {1'b0, hpos_q[6:1]} : hpos_q;
   assign stp_inc   = stp_l_q + 2'd1;
   assign stp_dec   = stp_l_q - 2'd1;
   assign need_save = dirty_q && ((tgt != track_q) || (mtr_l_q && !mtr));

   always_comb begin
      state_d      = state_q;
      hpos_d       = hpos_q;
      track_d      = track_q;
      stp_l_d      = stp;
      mtr_l_d      = mtr;
      dirty_d      = dirty_q | we;
      save_track_d = 1'b0;
      hold_d       = hold_q;

      // Stepping runs in both states; a step past either end is a bump stop.
      if (mtr) begin
         if (stp == stp_inc && hpos_q < hpos_max) begin
            hpos_d = hpos_q + 7'd1;
         end else if (stp == stp_dec && hpos_q != 7'd0) begin
            hpos_d = hpos_q - 7'd1;
         end
      end

      if (img_mounted) begin
         state_d = IDLE;
         dirty_d = 1'b0;
         hpos_d  = dir_hpos;
         track_d = dir_track;
         hold_d  = 16'd0;
      end else begin
         case (state_q)
            IDLE: begin
               // A concurrent write keeps dirty set: that data belongs to the saved track's successor save.
               if (need_save) begin
                  save_track_d = 1'b1;
                  dirty_d      = we;
                  hold_d       = 16'(HOLD_CYC);
                  state_d      = HOLD;
               end else if (tgt != track_q) begin
                  track_d = tgt;
               end
            end
            HOLD: begin
               if (hold_q == 16'd0) begin
                  track_d = tgt;
                  state_d = IDLE;
               end else begin
                  hold_d = hold_q - 16'd1;
               end
            end
            default: state_d = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk_sys) begin
      if (reset) begin
         state_q      <= IDLE;
         hpos_q       <= dir_hpos;
         track_q      <= dir_track;
         stp_l_q      <= stp;
         mtr_l_q      <= 1'b0;
         dirty_q      <= 1'b0;
         save_track_q <= 1'b0;
         hold_q       <= 16'd0;
      end else begin
         state_q      <= state_d;
         hpos_q       <= hpos_d;
         track_q      <= track_d;
         stp_l_q      <= stp_l_d;
         mtr_l_q      <= mtr_l_d;
         dirty_q      <= dirty_d;
         save_track_q <= save_track_d;
         hold_q       <= hold_d;
      end
   end

   assign track      = track_q;
   assign save_track = save_track_q;

endmodule
